// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forward
// selects and the result-source code that marks a load.
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hc_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // x0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side register/control bundle seen by the hazard controller.
// master = pipeline datapath, slave = hazard controller.
interface hazard_controller_if;
    import hazard_controller_pkg::*;

    logic [4:0] RS1D, RS2D;
    logic [4:0] RS1E, RS2E, RDE;
    logic [1:0] resultSrcE;
    logic       PCSrcE;
    logic [4:0] RDM, RDW;
    logic       regWriteM, regWriteW;
    logic       memReqM, memReadyM;

    logic       stallF, stallD, stallE, stallM, stallW;
    logic       flushD, flushE;
    logic [1:0] forwardAE, forwardBE;
    logic       memErr;
    hc_state_t  state;

    modport master (
        output RS1D, RS2D, RS1E, RS2E, RDE, resultSrcE, PCSrcE,
               RDM, RDW, regWriteM, regWriteW, memReqM, memReadyM,
        input  stallF, stallD, stallE, stallM, stallW, flushD, flushE,
               forwardAE, forwardBE, memErr, state
    );

    modport slave (
        input  RS1D, RS2D, RS1E, RS2E, RDE, resultSrcE, PCSrcE,
               RDM, RDW, regWriteM, regWriteW, memReqM, memReadyM,
        output stallF, stallD, stallE, stallM, stallW, flushD, flushE,
               forwardAE, forwardBE, memErr, state
    );

endinterface

// File: rtl/hazard_controller_forward_unit.sv
// Combinational ALU operand forward select for one Execute source register.
// Memory-stage result has priority over Writeback.
module forward_unit
    import hazard_controller_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && reg_match(rd_m, rs)) begin
            fwd = FWD_M;
        end else if (reg_write_w && reg_match(rd_w, rs)) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// 5-stage pipeline hazard unit: forwarding, load-use bubbles, redirects and a
// memory-wait freeze with timeout watchdog. HAZARD_PERF_CNT_EN adds perf counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_controller_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]         stallCycles,
    output logic [31:0]         flushEvents,
    output logic [31:0]         memWaitCycles
`endif
);

    hc_state_t        state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;

    logic       load_use;
    logic       timeout;
    logic       run_rules;
    logic       stall_all;
    logic       redirect;
    logic       bubble;
    logic [1:0] fwd_a, fwd_b;

    forward_unit u_fwd_a (
        .rs          (hz.RS1E),
        .rd_m        (hz.RDM),
        .reg_write_m (hz.regWriteM),
        .rd_w        (hz.RDW),
        .reg_write_w (hz.regWriteW),
        .fwd         (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs          (hz.RS2E),
        .rd_m        (hz.RDM),
        .reg_write_m (hz.regWriteM),
        .rd_w        (hz.RDW),
        .reg_write_w (hz.regWriteW),
        .fwd         (fwd_b)
    );

    assign load_use = (hz.resultSrcE == RESULT_SRC_LOAD) &&
                      (reg_match(hz.RDE, hz.RS1D) || reg_match(hz.RDE, hz.RS2D));
    assign timeout  = (wait_cnt_q == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // run_rules: the cycle behaves as RUN for redirect/bubble purposes,
    // including the cycle memory completes out of MEM_WAIT.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        stall_all  = 1'b0;
        run_rules  = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.memReqM && !hz.memReadyM) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                    stall_all  = 1'b1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (hz.memReadyM) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    run_rules  = 1'b1;
                end else if (timeout) begin
                    state_d   = ERROR;
                    mem_err_d = 1'b1;
                    stall_all = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    stall_all  = 1'b1;
                end
            end
            ERROR: begin
                mem_err_d = 1'b1;
                stall_all = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign redirect = run_rules && hz.PCSrcE;
    assign bubble   = run_rules && !hz.PCSrcE && load_use;

    // Reset drives clears into both registers so they come up as bubbles.
    always_comb begin
        hz.stallF    = 1'b0;
        hz.stallD    = 1'b0;
        hz.stallE    = 1'b0;
        hz.stallM    = 1'b0;
        hz.stallW    = 1'b0;
        hz.flushD    = 1'b1;
        hz.flushE    = 1'b1;
        hz.forwardAE = FWD_RF;
        hz.forwardBE = FWD_RF;
        if (rst_n) begin
            hz.stallF    = stall_all || bubble;
            hz.stallD    = stall_all || bubble;
            hz.stallE    = stall_all;
            hz.stallM    = stall_all;
            hz.stallW    = stall_all;
            hz.flushD    = redirect;
            hz.flushE    = redirect || bubble;
            hz.forwardAE = fwd_a;
            hz.forwardBE = fwd_b;
        end
    end

    assign hz.memErr = mem_err_q;
    assign hz.state  = state_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCycles   <= '0;
            flushEvents   <= '0;
            memWaitCycles <= '0;
        end else begin
            if (bubble && (stallCycles != '1)) begin
                stallCycles <= stallCycles + 32'd1;
            end
            if (redirect && (flushEvents != '1)) begin
                flushEvents <= flushEvents + 32'd1;
            end
            if (stall_all && (memWaitCycles != '1)) begin
                memWaitCycles <= memWaitCycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MEM_TIMEOUT=4) with an expected-value
// queue; covers HAZARD_PERF_CNT_EN counters when the macro is defined.
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    localparam int W = 14;
    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_FD   = 5'b11000;
    localparam logic [4:0] S_ALL  = 5'b11111;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [W-1:0] exp_q[$];

    hazard_controller_if hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stallCycles, flushEvents, memWaitCycles;
`endif

    hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stallCycles   (stallCycles),
        .flushEvents   (flushEvents),
        .memWaitCycles (memWaitCycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // {stallF,stallD,stallE,stallM,stallW, flushD,flushE, fwdA, fwdB, memErr, state}
    function automatic logic [W-1:0] ev(input logic [4:0] st, input logic fd, input logic fe,
                                        input logic [1:0] fa, input logic [1:0] fb,
                                        input logic err, input logic [1:0] s);
        return {st, fd, fe, fa, fb, err, s};
    endfunction

    function automatic logic [W-1:0] obs_vec();
        return {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW,
                hz.flushD, hz.flushE, hz.forwardAE, hz.forwardBE, hz.memErr,
                2'(hz.state)};
    endfunction

    task automatic idle_inputs();
        hz.RS1D = 0; hz.RS2D = 0; hz.RS1E = 0; hz.RS2E = 0; hz.RDE = 0;
        hz.resultSrcE = 2'b00; hz.PCSrcE = 1'b0;
        hz.RDM = 0; hz.RDW = 0; hz.regWriteM = 1'b0; hz.regWriteW = 1'b0;
        hz.memReqM = 1'b0; hz.memReadyM = 1'b0;
    endtask

    task automatic check(input string tag);
        logic [W-1:0] o;
        logic [W-1:0] e;
        o = obs_vec();
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard queue empty, observed %h", tag, o);
        end else begin
            e = exp_q.pop_front();
            assert (o === e) else begin
                failures++;
                $error("FAIL %s: observed %b expected %b", tag, o, e);
            end
        end
    endtask

    // Inputs already driven; push expectation, sample mid-cycle, then advance.
    task automatic step(input string tag, input logic [W-1:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        check(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        rst_n = 1'b0;
        hz.regWriteM = 1'b1; hz.RDM = 5'd5; hz.RS1E = 5'd5;
        @(posedge clk); #1;
        step("reset_outputs", ev(S_NONE, 1, 1, FWD_RF, FWD_RF, 0, RUN));

        rst_n = 1'b1;
        idle_inputs();
        step("idle_after_reset", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, RUN));

        hz.regWriteM = 1; hz.RDM = 5; hz.RS1E = 5; hz.regWriteW = 1; hz.RDW = 5; hz.RS2E = 9;
        step("fwdA_m_priority", ev(S_NONE, 0, 0, FWD_M, FWD_RF, 0, RUN));
        hz.RDM = 0;
        step("fwdA_w_when_rdm0", ev(S_NONE, 0, 0, FWD_W, FWD_RF, 0, RUN));
        hz.RDW = 0;
        step("fwdA_rf_when_rdw0", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, RUN));

        hz.RDM = 3; hz.RDW = 3; hz.RS1E = 3; hz.RS2E = 3;
        step("fwdAB_both_m", ev(S_NONE, 0, 0, FWD_M, FWD_M, 0, RUN));
        hz.regWriteM = 0;
        step("fwdAB_both_w", ev(S_NONE, 0, 0, FWD_W, FWD_W, 0, RUN));
        hz.regWriteW = 0;
        step("fwdAB_no_write", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, RUN));

        idle_inputs();
        hz.resultSrcE = RESULT_SRC_LOAD; hz.RDE = 7; hz.RS2D = 7;
        step("load_use_bubble", ev(S_FD, 0, 1, FWD_RF, FWD_RF, 0, RUN));
        hz.resultSrcE = 2'b00;
        step("load_use_released", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, RUN));
        hz.resultSrcE = RESULT_SRC_LOAD; hz.RDE = 0; hz.RS1D = 0; hz.RS2D = 0;
        step("load_x0_no_hazard", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, RUN));

        hz.RDE = 7; hz.RS1D = 7; hz.PCSrcE = 1;
        step("redirect_beats_load_use", ev(S_NONE, 1, 1, FWD_RF, FWD_RF, 0, RUN));
        idle_inputs();
        hz.PCSrcE = 1;
        step("redirect_alone", ev(S_NONE, 1, 1, FWD_RF, FWD_RF, 0, RUN));

        idle_inputs();
        hz.memReqM = 1; hz.memReadyM = 1;
        step("mem_single_cycle", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, RUN));

        hz.memReadyM = 0;
        step("mem_wait_enter", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, RUN));
        step("mem_wait_2", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, MEM_WAIT));
        step("mem_wait_3", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, MEM_WAIT));
        hz.memReadyM = 1;
        step("mem_ready_release", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, MEM_WAIT));
        idle_inputs();
        step("mem_back_to_run", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, RUN));

        hz.memReqM = 1;
        step("held_redirect_enter", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, RUN));
        hz.PCSrcE = 1;
        step("held_redirect_frozen", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, MEM_WAIT));
        hz.memReadyM = 1;
        step("held_redirect_applied", ev(S_NONE, 1, 1, FWD_RF, FWD_RF, 0, MEM_WAIT));
        idle_inputs();
        hz.memReqM = 1;
        step("held_load_enter", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, RUN));
        hz.resultSrcE = RESULT_SRC_LOAD; hz.RDE = 7; hz.RS1D = 7;
        step("held_load_frozen", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, MEM_WAIT));
        hz.memReadyM = 1;
        step("held_load_applied", ev(S_FD, 0, 1, FWD_RF, FWD_RF, 0, MEM_WAIT));
        idle_inputs();
        step("held_load_run", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, RUN));

        // Counter reaches MEM_TIMEOUT on the same cycle ready arrives.
        hz.memReqM = 1;
        step("race_enter", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, RUN));
        for (int i = 0; i < 3; i++) begin
            step($sformatf("race_wait_%0d", i), ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, MEM_WAIT));
        end
        hz.memReadyM = 1;
        step("race_ready_wins", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, MEM_WAIT));
        idle_inputs();
        step("race_run", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, RUN));

        hz.memReqM = 1;
        step("to_enter", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, RUN));
        for (int i = 0; i < 4; i++) begin
            step($sformatf("to_wait_%0d", i), ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, MEM_WAIT));
        end
        step("to_error", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 1, ERROR));
        hz.memReadyM = 1; hz.PCSrcE = 1;
        hz.regWriteM = 1; hz.RDM = 4; hz.RS1E = 4;
        step("error_sticky", ev(S_ALL, 0, 0, FWD_M, FWD_RF, 1, ERROR));
        step("error_sticky_2", ev(S_ALL, 0, 0, FWD_M, FWD_RF, 1, ERROR));

        idle_inputs();
        rst_n = 1'b0;
        step("error_reset", ev(S_NONE, 1, 1, FWD_RF, FWD_RF, 0, RUN));
        rst_n = 1'b1;
        step("error_reset_idle", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, RUN));

        hz.memReqM = 1;
        step("midwait_enter", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, RUN));
        step("midwait_wait", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, MEM_WAIT));
        rst_n = 1'b0;
        step("midwait_reset", ev(S_NONE, 1, 1, FWD_RF, FWD_RF, 0, RUN));
        idle_inputs();
        rst_n = 1'b1;
        step("midwait_idle", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, RUN));

`ifdef HAZARD_PERF_CNT_EN
        rst_n = 1'b0;
        step("perf_reset", ev(S_NONE, 1, 1, FWD_RF, FWD_RF, 0, RUN));
        chk32("perf_stall_reset", stallCycles, 32'd0);
        chk32("perf_flush_reset", flushEvents, 32'd0);
        chk32("perf_wait_reset", memWaitCycles, 32'd0);
        rst_n = 1'b1;
        hz.resultSrcE = RESULT_SRC_LOAD; hz.RDE = 7; hz.RS2D = 7;
        step("perf_bubble_1", ev(S_FD, 0, 1, FWD_RF, FWD_RF, 0, RUN));
        step("perf_bubble_2", ev(S_FD, 0, 1, FWD_RF, FWD_RF, 0, RUN));
        idle_inputs();
        hz.PCSrcE = 1;
        step("perf_redirect", ev(S_NONE, 1, 1, FWD_RF, FWD_RF, 0, RUN));
        idle_inputs();
        hz.memReqM = 1;
        step("perf_wait_1", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, RUN));
        step("perf_wait_2", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, MEM_WAIT));
        step("perf_wait_3", ev(S_ALL, 0, 0, FWD_RF, FWD_RF, 0, MEM_WAIT));
        hz.memReadyM = 1;
        step("perf_ready", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, MEM_WAIT));
        idle_inputs();
        step("perf_idle", ev(S_NONE, 0, 0, FWD_RF, FWD_RF, 0, RUN));
        chk32("perf_stallCycles", stallCycles, 32'd2);
        chk32("perf_flushEvents", flushEvents, 32'd1);
        chk32("perf_memWaitCycles", memWaitCycles, 32'd3);
`endif

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL queue_drained: observed %0d left expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central hazard and sequencing unit for the 5-stage pipeline; drives stall, clear and forward controls for the F/D, D/E, E/M and M/W pipeline registers.
- Resolves load-use hazards, taken-branch/jump redirects and register forwarding.
- Freezes the whole pipeline while a multi-cycle data-memory access is outstanding; a wait-timeout watchdog escalates to a sticky error.

Parameters:
- MEM_TIMEOUT, 64, max consecutive wait cycles before error; legal range 2..65535.
- CNT_W, 16, width of wait counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- RS1D, RS2D  in  5  source regs in Decode
- RS1E, RS2E, RDE  in  5  source/dest regs in Execute
- resultSrcE  in  2  2'b01 = load in Execute
- PCSrcE  in  1  taken branch/jal/jalr resolved in Execute
- RDM, RDW  in  5  dest regs in Memory/Writeback
- regWriteM, regWriteW  in  1  write enables in Memory/Writeback
- memReqM  in  1  data-memory access active in Memory
- memReadyM  in  1  data memory completes this cycle
- stallF, stallD, stallE, stallM, stallW  out  1  hold the respective stage register
- flushD, flushE  out  1  synchronous clear of F/D and D/E registers
- forwardAE, forwardBE  out  2  ALU operand select: 00 register file, 01 from W, 10 from M
- memErr  out  1  sticky timeout error

Behaviour:
- Reset: clk and rst_n only; rst_n low forces state RUN, waitCnt=0, memErr=0. Outputs while in reset: all stalls 0, flushD=flushE=1, forwards 00.
- States: RUN, MEM_WAIT, ERROR; 2-bit encoding, registered.
- Forwarding: combinational, valid in every state.
  - forwardAE=10 if regWriteM && RDM!=0 && RDM==RS1E.
  - Else 01 if regWriteW && RDW!=0 && RDW==RS1E.
  - Else 00.
  - forwardBE is identical on RS2E. M has priority over W.
- loadUse = (resultSrcE==2'b01) && RDE!=0 && (RDE==RS1D || RDE==RS2D).
- RUN outputs:
  - PCSrcE=1: flushD=1, flushE=1, stallF=stallD=0. Redirect wins over loadUse; loadUse is ignored.
  - Else loadUse=1: stallF=stallD=1, flushE=1 (one bubble, one cycle).
  - stallE/M/W=0.
- RUN to MEM_WAIT: memReqM && !memReadyM. In that same cycle stallF..stallW=1 combinationally and flushes=0; waitCnt loads 1.
- MEM_WAIT:
  - stallF..stallW=1, flushD=flushE=0. A pending PCSrcE or loadUse is held in place and acted on after release.
  - waitCnt increments each cycle.
  - memReadyM=1: stalls drop in that cycle (combinational), next state RUN, waitCnt cleared. The RUN rules for PCSrcE/loadUse apply in that same cycle.
  - waitCnt==MEM_TIMEOUT with memReadyM=0: next state ERROR.
  - memReadyM and timeout in the same cycle: ready wins, next state RUN.
- ERROR: memErr=1, all stalls 1, flushes 0. Exited only by reset.
- memReqM with memReadyM=1 in RUN: single-cycle access, no stall.
- rst_n asserted mid-wait: immediate return to RUN, counter and memErr cleared.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds 32-bit outputs stallCycles, flushEvents and memWaitCycles, all reset to 0 and all saturating at 32'hFFFFFFFF.
  - stallCycles increments each cycle loadUse causes a bubble.
  - flushEvents increments each PCSrcE redirect.
  - memWaitCycles increments each cycle stallW=1.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package: state encoding (RUN=0, MEM_WAIT=1, ERROR=2), forward-select constants (FWD_RF=00, FWD_W=01, FWD_M=10), RESULT_SRC_LOAD=2'b01.
- One sub-module: forward_unit, the combinational forward select, instantiated twice (A and B).
- FSM, watchdog and stall/flush logic stay in the top.

Test Plan:
- regWriteM=1, RDM=5, RS1E=5, plus regWriteW=1, RDW=5 -> forwardAE=10. With RDM=0 instead -> forwardAE=01. RDW=0 also -> 00.
- resultSrcE=01, RDE=7, RS2D=7, PCSrcE=0 -> stallF=stallD=flushE=1 for exactly one cycle. Next cycle, with resultSrcE changed, all deasserted.
- loadUse condition plus PCSrcE=1 same cycle -> flushD=flushE=1, stallF=stallD=0.
- memReqM=1, memReadyM low for 3 cycles then high -> stallF..stallW=1 for 3 cycles, 0 on the ready cycle, state back to RUN.
- MEM_TIMEOUT=4, memReadyM held 0 -> ERROR after 4 wait cycles, memErr=1 and all stalls stuck. rst_n pulse low -> memErr=0, state RUN, flushD=flushE=1 during reset.
- With HAZARD_PERF_CNT_EN defined: 2 load-use bubbles, 1 redirect, 3 wait cycles -> stallCycles=2, flushEvents=1, memWaitCycles=3.
